// File: rtl/div_share_ctrl.sv
// div_share_ctrl: round-robin shared 16-bit restoring divider; DIV_ZERO_FLAG_EN adds the dz output
module div_share_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    output logic        ack0,
    output logic        ack1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] q,
    output logic [15:0] r,
    output logic        busy
`ifdef DIV_ZERO_FLAG_EN
    ,
    output logic        dz
`endif
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
    logic [1:0]  state_q, state_d;
    logic        last_q, last_d, gnt_q, gnt_d, ack_q, ack_d, done_q, done_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] dvd_q, dvd_d, div_q, div_d, rem_q, rem_d, q_q, q_d, r_q, r_d;
    logic [16:0] rem_sh, sub;
    logic        ge, pick;
`ifdef DIV_ZERO_FLAG_EN
    logic        dz_q, dz_d;
    assign dz = dz_q;
`endif
    assign pick   = (req0 & req1) ? ~last_q : req1;
    assign rem_sh = {rem_q, dvd_q[15]};
    assign sub    = rem_sh - {1'b0, div_q};
    // rem < divisor always holds, so a borrow out of the subtract means rem_sh < divisor
    assign ge     = ~sub[16];
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        ack_d   = 1'b0;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        div_d   = div_q;
        rem_d   = rem_q;
        q_d     = q_q;
        r_d     = r_q;
`ifdef DIV_ZERO_FLAG_EN
        dz_d    = 1'b0;
`endif
        case (state_q)
            IDLE: if (req0 | req1) begin
                gnt_d   = pick;
                last_d  = pick;
                ack_d   = 1'b1;
                dvd_d   = pick ? a1 : a0;
                div_d   = pick ? b1 : b0;
                rem_d   = '0;
                cnt_d   = '0;
                state_d = (div_d == 16'd0) ? DONE : RUN;
            end
            RUN: begin
                // quotient bits shift into the low end as dividend bits leave the top
                rem_d = ge ? sub[15:0] : rem_sh[15:0];
                dvd_d = {dvd_q[14:0], ge};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd15) begin
                    q_d     = dvd_d;
                    r_d     = rem_d;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: if (done_q) begin
                state_d = IDLE;
            end else begin
                q_d    = 16'hFFFF;
                r_d    = dvd_q;
                done_d = 1'b1;
`ifdef DIV_ZERO_FLAG_EN
                dz_d   = 1'b1;
`endif
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            dvd_q   <= '0;
            div_q   <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
`ifdef DIV_ZERO_FLAG_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            r_q     <= r_d;
`ifdef DIV_ZERO_FLAG_EN
            dz_q    <= dz_d;
`endif
        end
    end
    assign ack0  = ack_q & ~gnt_q;
    assign ack1  = ack_q & gnt_q;
    assign done0 = done_q & ~gnt_q;
    assign done1 = done_q & gnt_q;
    assign q     = q_q;
    assign r     = r_q;
    assign busy  = state_q != IDLE;
endmodule
